mul_flag_unit: RTL
==================

Name: mul_flag_unit

Overview:
- Iterative shift-add multiplier for MUL/MLA(S); the producer end of the flag-write interface that the condition unit consumes.
- Sits in the execute stage beside the ALU, stalls the pipeline via busy, and on completion issues Result, FlagsOut and a one-cycle FlagWrite.
- FlagWrite encoding is shared with the condition unit: bit1 writes N,Z (Flags[3:2]); bit0 writes C,V (Flags[1:0]).

Parameters:
WIDTH, 32, operand/result width in bits; iteration count = WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
flush  in  1  synchronous abort (pipeline flush).
Accumulate  in  1  1 = MLA (add SrcAcc), 0 = MUL.
SetFlags  in  1  S bit; enables FlagWrite on completion.
SrcA  in  WIDTH  multiplicand.
SrcB  in  WIDTH  multiplier.
SrcAcc  in  WIDTH  accumulate operand.
FlagsIn  in  4  current NZCV; C,V sampled at start.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle completion pulse.
Result  out  WIDTH  low WIDTH bits of SrcA*SrcB (+SrcAcc).
FlagsOut  out  4  {N, Z, C, V} for the completed operation.
FlagWrite  out  2  2'b10 during done if SetFlags latched, else 2'b00.

Behaviour:
- Reset (reset low, async): state=IDLE; busy=0, done=0, Result=0, FlagsOut=0, FlagWrite=0, counter=0, all operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0 at an edge:
  - latch SrcA, SrcB, Accumulate, SetFlags, FlagsIn[1:0];
  - acc <= Accumulate ? SrcAcc : 0; counter <= 0; next state RUN.
- RUN, each edge:
  - if mcand_lsb... specifically, if multiplier[0]=1, acc <= acc + multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1; counter++;
  - after the WIDTH-th RUN edge, Result <= acc and next state DONE.
- Counter width is clog2(WIDTH)+1. No early termination; latency is fixed.
- DONE (exactly one cycle):
  - done=1; FlagWrite = SetFlags ? 2'b10 : 2'b00;
  - FlagsOut = {Result[WIDTH-1], Result==0, latched C, latched V};
  - next state IDLE.
- Latency: done is high in the cycle following the (WIDTH+1)-th rising edge after the start-sampling edge, counting that edge as edge 1. For WIDTH=32, done appears 33 cycles after start is sampled.
- Outputs outside DONE: done=0 and FlagWrite=0 in all other states. Result and FlagsOut hold their last values until the next completion.
- busy: 1 in RUN and DONE, 0 in IDLE. Goes high the cycle after start is sampled.
- start while busy: ignored, with no queuing. start in the DONE cycle is also ignored; a new op is accepted only once back in IDLE.
- flush (any state, synchronous):
  - next state IDLE; no done, no FlagWrite;
  - Result and FlagsOut keep their previous values.
  - flush and start together in IDLE: flush wins, and the op is not accepted.
- Mid-operation async reset: immediate return to reset values; no done is ever emitted for the aborted op.
- Arithmetic: all sums truncated to WIDTH bits. Signed and unsigned operands give identical low bits. C and V are never computed and always pass through from FlagsIn.

Test Plan:
- Reset: hold reset low for 3 cycles, release -> busy=0, done=0, Result=0, FlagsOut=4'b0000, FlagWrite=2'b00.
- MULS: SrcA=7, SrcB=6, SetFlags=1, FlagsIn=4'b0011, one start pulse -> done pulses once, 33 cycles later; Result=42, FlagsOut=4'b0011, FlagWrite=2'b10 for that cycle only.
- Zero/wrap: SrcA=32'h8000_0000, SrcB=2, SetFlags=1, FlagsIn=4'b0000 -> Result=0, FlagsOut=4'b0100. Then SrcA=32'hFFFF_FFFF, SrcB=1 -> Result=FFFF_FFFF, FlagsOut[3]=1.
- MLA without S: SrcA=3, SrcB=5, SrcAcc=100, Accumulate=1, SetFlags=0 -> Result=115, FlagWrite=2'b00 during done.
- start held high continuously for 80 cycles with operands changing -> exactly two ops complete, done pulses spaced 34 cycles apart; each Result matches the operands present at its accepting edge.
- Abort: start an op, assert flush at cycle 10 -> busy=0 next cycle, no done, Result unchanged. Repeat with reset pulsed low at cycle 10 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mul_flag_unit.sv
// -----------------------------------------------------------------------------
// mul_flag_unit
//
// Iterative shift-add multiplier for MUL / MLA(S) in the execute stage.
// It drives the flag-write interface that the condition unit consumes.
// The operation takes a fixed WIDTH iterations with no early exit.
// On completion the unit raises done for one cycle and presents Result,
// FlagsOut and FlagWrite.
//
// FlagWrite encoding is shared with the condition unit:
//   bit1 writes N,Z (Flags[3:2]); bit0 writes C,V (Flags[1:0]).
// A multiply only produces N and Z, so bit0 is never set.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   operation request, sampled only in IDLE
//   flush      in   synchronous abort; wins over start
//   Accumulate in   1 = MLA (seed accumulator with SrcAcc), 0 = MUL
//   SetFlags   in   S bit; enables FlagWrite on completion
//   SrcA       in   multiplicand            [WIDTH]
//   SrcB       in   multiplier              [WIDTH]
//   SrcAcc     in   accumulate operand      [WIDTH]
//   FlagsIn    in   current NZCV; C,V captured at start
//   busy       out  high in RUN and DONE
//   done       out  one-cycle completion pulse
//   Result     out  low WIDTH bits of SrcA*SrcB (+SrcAcc), held between ops
//   FlagsOut   out  {N, Z, C, V} of the last completed op, held between ops
//   FlagWrite  out  2'b10 during done when SetFlags was latched, else 2'b00
// -----------------------------------------------------------------------------
module mul_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             Accumulate,
    input  logic             SetFlags,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcAcc,
    input  logic [3:0]       FlagsIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       FlagsOut,
    output logic [1:0]       FlagWrite
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] mcand_q,    mcand_d;
    logic [WIDTH-1:0] mplier_q,   mplier_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] counter_q,  counter_d;
    logic             setflags_q, setflags_d;
    logic [1:0]       cv_q,       cv_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic [3:0]       flags_q,    flags_d;

    // N and Z are produced here, never consumed from the incoming flags.
    logic flags_nz_unused;
    assign flags_nz_unused = ^FlagsIn[3:2];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // a value unassigned and no latch is inferred.
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        counter_d  = counter_q;
        setflags_d = setflags_q;
        cv_d       = cv_q;
        result_d   = result_q;
        flags_d    = flags_q;

        if (flush) begin
            // Abort from any state. Result and FlagsOut keep the last completed op.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_d    = SrcA;
                        mplier_d   = SrcB;
                        acc_d      = Accumulate ? SrcAcc : '0;
                        counter_d  = '0;
                        setflags_d = SetFlags;
                        cv_d       = FlagsIn[1:0];
                        state_d    = RUN;
                    end
                end

                RUN: begin
                    // One partial product per cycle. The sum wraps modulo 2^WIDTH,
                    // so signed and unsigned operands give the same low bits.
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    counter_d = counter_q + CNT_W'(1);

                    // Last iteration: publish the final sum and its flags together.
                    // They then hold until the next completion.
                    if (counter_q == CNT_W'(WIDTH - 1)) begin
                        result_d = acc_d;
                        flags_d  = {acc_d[WIDTH-1], (acc_d == '0), cv_q};
                        state_d  = DONE;
                    end
                end

                DONE: begin
                    // Exactly one cycle. A start seen here is dropped, not queued.
                    state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every register, including the operand and accumulator datapath, is
    // cleared on reset. An aborted op therefore leaves nothing behind that
    // could later surface as a done or a stale Result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            counter_q  <= '0;
            setflags_q <= 1'b0;
            cv_q       <= 2'b00;
            result_q   <= '0;
            flags_q    <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // from before this edge regardless of statement order.
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            counter_q  <= counter_d;
            setflags_q <= setflags_d;
            cv_q       <= cv_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign FlagWrite = (done && setflags_q) ? 2'b10 : 2'b00;
    assign Result    = result_q;
    assign FlagsOut  = flags_q;

endmodule
